aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
- Upstream feeder for the AES encryption core.
- Accepts a byte-serial stream tagged as key or plaintext and assembles 16-byte plaintext blocks plus a 16-byte key into parallel byte registers.
- Presents each block to the core with a valid/ready handshake.
- The key persists across blocks unless reloaded, so a stream of plaintext blocks can run under one key.

Parameters:
- CNT_W, 16, width of the handed-off block counter.
- PERSIST_KEY, 1, 1 = key stays loaded after handoff; 0 = key_loaded clears on each handoff, so every block needs a fresh key.

Ports:
- sys_clk  input  1  single system clock; all logic rising-edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of counters, key_loaded and state.
- s_valid  input  1  input byte valid.
- s_is_key  input  1  1 = byte is key, 0 = byte is plaintext.
- s_data  input  8  input byte.
- s_ready  output  1  loader accepts the byte this cycle.
- ptext0..ptext15  output  8 each  assembled plaintext; byte 0 is the first received.
- key0..key15  output  8 each  assembled key; byte 0 is the first received.
- out_valid  output  1  block and key are stable and presented.
- out_ready  input  1  downstream core takes the block.
- key_loaded  output  1  all 16 key bytes are held.
- blk_count  output  CNT_W  number of completed handoffs; wraps.

Behaviour:
- Reset (sys_rst_n low, async) clears all outputs: ptext*, key*, blk_count, out_valid, key_loaded and s_ready go to 0; state = FILL; pt_idx = 0; key_idx = 0. s_ready reasserts combinationally from state on the first cycle after reset release.
- A byte is accepted only when s_valid && s_ready. pt_idx and key_idx are 4-bit write pointers into the respective register banks.
- FILL state:
  - s_ready = 1.
  - Plaintext byte: written to ptext[pt_idx]; pt_idx increments.
  - Key byte: written to key[key_idx]; key_idx increments.
  - Key byte with key_idx == 0 and key_loaded == 1 starts a reload: key_loaded clears that cycle.
  - key_loaded sets on acceptance of the byte at key_idx == 15; key_idx wraps to 0.
  - Plaintext byte at pt_idx == 15: pt_idx wraps to 0. Next state is PRESENT if the key is complete, otherwise WAIT_KEY.
  - "Key complete" means key_loaded is already 1, or the same cycle sets it. Key and plaintext bytes are never accepted in the same cycle, so that case only arises through the already-set path.
- WAIT_KEY state:
  - s_ready = s_is_key. Plaintext bytes are back-pressured.
  - Key bytes are handled exactly as in FILL.
  - When key_loaded becomes 1, go to PRESENT.
- PRESENT state:
  - out_valid = 1 and s_ready = 0.
  - ptext* and key* are held stable.
  - On out_ready: out_valid drops the next cycle; blk_count increments, wrapping modulo 2^CNT_W; state returns to FILL. If PERSIST_KEY == 0, key_loaded and key_idx clear.
- Latency: out_valid is registered and rises the cycle after the completing byte (16th plaintext or 16th key) is accepted.
- out_ready while not in PRESENT is ignored.
- flush has priority over every other event in the same cycle:
  - state = FILL; pt_idx = 0; key_idx = 0; key_loaded = 0; out_valid = 0.
  - ptext*, key* and blk_count retain their values.
- Reset asserted mid-block discards the partial block; no handoff is counted.
- A partial key reload leaves key_loaded = 0. The next block waits in WAIT_KEY until 16 key bytes have been received.

Test Plan:
- Load FIPS-197 key 00 01 .. 0f, then plaintext 00 11 22 .. ff -> out_valid rises exactly 1 cycle after the 16th pt byte; key0 = 00, key15 = 0f, ptext0 = 00, ptext15 = ff; hold out_ready = 0 for 5 cycles -> outputs stable and s_ready = 0; then out_ready = 1 -> blk_count = 1 and state FILL.
- Send 16 plaintext bytes first with no key -> enters WAIT_KEY with s_ready = 0 for plaintext; send 16 key bytes -> out_valid rises 1 cycle after key15 is accepted.
- With PERSIST_KEY = 1, send three plaintext blocks back-to-back after one key, with out_ready held 1 -> three handoffs, blk_count = 3, key unchanged; with PERSIST_KEY = 0 the second block stalls in WAIT_KEY.
- Mid-block (8 pt bytes received), pulse flush together with s_valid -> byte not stored; pt_idx = 0 and key_loaded = 0; the next 16 pt bytes land at ptext0..ptext15.
- Reload 5 key bytes (aa..ae) after key_loaded = 1 -> key_loaded = 0 and key0..key4 = aa..ae; the next completed plaintext block waits in WAIT_KEY until key_idx wraps.
- Preset blk_count to 2^CNT_W - 1 via repeated handoffs (CNT_W = 4 build, 15 handoffs), then do one more handoff -> blk_count wraps to 0; assert sys_rst_n low mid-PRESENT -> out_valid = 0 immediately (async) and all outputs are 0.

Source files
------------

// File: rtl/aes_block_loader.sv
// aes_block_loader: byte-serial feeder for the AES core.
// Assembles a 16-byte key and 16-byte plaintext block from a tagged byte
// stream. It then presents both to the core with a valid/ready handshake.
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   flush                     synchronous clear of pointers, key_loaded, state
//   s_valid/s_is_key/s_data   input byte stream (s_is_key=1 tags a key byte)
//   s_ready                   byte accepted this cycle (combinational from state)
//   ptext0..15, key0..15      assembled block and key, byte 0 = first received
//   out_valid/out_ready       handoff handshake to the core
//   key_loaded                all 16 key bytes held
//   blk_count                 completed handoffs, wrapping
module aes_block_loader #(
   parameter int unsigned CNT_W       = 16,
   parameter bit          PERSIST_KEY = 1'b1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             flush,
   input  logic             s_valid,
   input  logic             s_is_key,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic [7:0]       ptext0,
   output logic [7:0]       ptext1,
   output logic [7:0]       ptext2,
   output logic [7:0]       ptext3,
   output logic [7:0]       ptext4,
   output logic [7:0]       ptext5,
   output logic [7:0]       ptext6,
   output logic [7:0]       ptext7,
   output logic [7:0]       ptext8,
   output logic [7:0]       ptext9,
   output logic [7:0]       ptext10,
   output logic [7:0]       ptext11,
   output logic [7:0]       ptext12,
   output logic [7:0]       ptext13,
   output logic [7:0]       ptext14,
   output logic [7:0]       ptext15,
   output logic [7:0]       key0,
   output logic [7:0]       key1,
   output logic [7:0]       key2,
   output logic [7:0]       key3,
   output logic [7:0]       key4,
   output logic [7:0]       key5,
   output logic [7:0]       key6,
   output logic [7:0]       key7,
   output logic [7:0]       key8,
   output logic [7:0]       key9,
   output logic [7:0]       key10,
   output logic [7:0]       key11,
   output logic [7:0]       key12,
   output logic [7:0]       key13,
   output logic [7:0]       key14,
   output logic [7:0]       key15,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             key_loaded,
   output logic [CNT_W-1:0] blk_count
);

   localparam int unsigned NUM_BYTES = 16;
   localparam int unsigned IDX_W     = 4;

   typedef enum logic [1:0] {
      ST_FILL     = 2'd0,
      ST_WAIT_KEY = 2'd1,
      ST_PRESENT  = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] pt_idx_q;
   logic [IDX_W-1:0] key_idx_q;
   logic [7:0]       pt_q  [NUM_BYTES];
   logic [7:0]       key_q [NUM_BYTES];

   logic accept;
   logic pt_acc;
   logic key_acc;
   logic pt_last;
   logic key_last;

   // Ready follows state directly; held low while reset is asserted.
   assign s_ready = sys_rst_n &&
                    ((state_q == ST_FILL) || ((state_q == ST_WAIT_KEY) && s_is_key));

   assign accept   = s_valid && s_ready;
   assign pt_acc   = accept && !s_is_key;
   assign key_acc  = accept && s_is_key;
   assign pt_last  = (pt_idx_q == IDX_W'(NUM_BYTES - 1));
   assign key_last = (key_idx_q == IDX_W'(NUM_BYTES - 1));

   // Byte capture, pointers, key status, handoff and block counter.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ST_FILL;
         pt_idx_q   <= '0;
         key_idx_q  <= '0;
         key_loaded <= 1'b0;
         out_valid  <= 1'b0;
         blk_count  <= '0;
         for (int i = 0; i < NUM_BYTES; i++) begin
            pt_q[i]  <= '0;
            key_q[i] <= '0;
         end
      end else if (flush) begin
         state_q    <= ST_FILL;
         pt_idx_q   <= '0;
         key_idx_q  <= '0;
         key_loaded <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         // Key bytes are legal in FILL and WAIT_KEY.
         if (key_acc) begin
            key_q[key_idx_q] <= s_data;
            key_idx_q        <= key_idx_q + IDX_W'(1);
            if (key_last) begin
               key_loaded <= 1'b1;
            end else if ((key_idx_q == '0) && key_loaded) begin
               // First byte of a new key invalidates the old one.
               key_loaded <= 1'b0;
            end
            if (key_last && (state_q == ST_WAIT_KEY)) begin
               state_q   <= ST_PRESENT;
               out_valid <= 1'b1;
            end
         end

         // Plaintext bytes are only accepted in FILL.
         if (pt_acc) begin
            pt_q[pt_idx_q] <= s_data;
            pt_idx_q       <= pt_idx_q + IDX_W'(1);
            if (pt_last) begin
               if (key_loaded) begin
                  state_q   <= ST_PRESENT;
                  out_valid <= 1'b1;
               end else begin
                  state_q <= ST_WAIT_KEY;
               end
            end
         end

         if ((state_q == ST_PRESENT) && out_ready) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + CNT_W'(1);
            state_q   <= ST_FILL;
            if (!PERSIST_KEY) begin
               key_loaded <= 1'b0;
               key_idx_q  <= '0;
            end
         end
      end
   end

   assign ptext0  = pt_q[0];
   assign ptext1  = pt_q[1];
   assign ptext2  = pt_q[2];
   assign ptext3  = pt_q[3];
   assign ptext4  = pt_q[4];
   assign ptext5  = pt_q[5];
   assign ptext6  = pt_q[6];
   assign ptext7  = pt_q[7];
   assign ptext8  = pt_q[8];
   assign ptext9  = pt_q[9];
   assign ptext10 = pt_q[10];
   assign ptext11 = pt_q[11];
   assign ptext12 = pt_q[12];
   assign ptext13 = pt_q[13];
   assign ptext14 = pt_q[14];
   assign ptext15 = pt_q[15];

   assign key0  = key_q[0];
   assign key1  = key_q[1];
   assign key2  = key_q[2];
   assign key3  = key_q[3];
   assign key4  = key_q[4];
   assign key5  = key_q[5];
   assign key6  = key_q[6];
   assign key7  = key_q[7];
   assign key8  = key_q[8];
   assign key9  = key_q[9];
   assign key10 = key_q[10];
   assign key11 = key_q[11];
   assign key12 = key_q[12];
   assign key13 = key_q[13];
   assign key14 = key_q[14];
   assign key15 = key_q[15];

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: scoreboard of expected handoffs checked by a
// monitor on out_valid && out_ready, plus directed checks on status signals.
// dut: CNT_W=4, PERSIST_KEY=1. dut_np: CNT_W=16, PERSIST_KEY=0.
module tb_aes_block_loader;

   typedef struct packed {
      logic [127:0] pt;
      logic [127:0] key;
      logic [3:0]   cnt;
   } exp_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       flush;
   logic       s_valid;
   logic       np_valid;
   logic       s_is_key;
   logic [7:0] s_data;
   logic       out_ready;
   logic       np_ready;

   logic       s_ready, out_valid, key_loaded;
   logic [3:0] blk_count;
   logic [7:0] pt_b  [16];
   logic [7:0] key_b [16];

   logic        np_s_ready, np_out_valid, np_key_loaded;
   logic [15:0] np_blk_count;
   logic [7:0]  np_pt_b  [16];
   logic [7:0]  np_key_b [16];

   logic [127:0] pt_bus, key_bus, np_pt_bus, np_key_bus;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 sys_clk = ~sys_clk;

   always_comb begin
      pt_bus = '0; key_bus = '0; np_pt_bus = '0; np_key_bus = '0;
      for (int i = 0; i < 16; i++) begin
         pt_bus[8*i +: 8]     = pt_b[i];
         key_bus[8*i +: 8]    = key_b[i];
         np_pt_bus[8*i +: 8]  = np_pt_b[i];
         np_key_bus[8*i +: 8] = np_key_b[i];
      end
   end

   aes_block_loader #(.CNT_W(4), .PERSIST_KEY(1'b1)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush),
      .s_valid(s_valid), .s_is_key(s_is_key), .s_data(s_data), .s_ready(s_ready),
      .ptext0(pt_b[0]), .ptext1(pt_b[1]), .ptext2(pt_b[2]), .ptext3(pt_b[3]),
      .ptext4(pt_b[4]), .ptext5(pt_b[5]), .ptext6(pt_b[6]), .ptext7(pt_b[7]),
      .ptext8(pt_b[8]), .ptext9(pt_b[9]), .ptext10(pt_b[10]), .ptext11(pt_b[11]),
      .ptext12(pt_b[12]), .ptext13(pt_b[13]), .ptext14(pt_b[14]), .ptext15(pt_b[15]),
      .key0(key_b[0]), .key1(key_b[1]), .key2(key_b[2]), .key3(key_b[3]),
      .key4(key_b[4]), .key5(key_b[5]), .key6(key_b[6]), .key7(key_b[7]),
      .key8(key_b[8]), .key9(key_b[9]), .key10(key_b[10]), .key11(key_b[11]),
      .key12(key_b[12]), .key13(key_b[13]), .key14(key_b[14]), .key15(key_b[15]),
      .out_valid(out_valid), .out_ready(out_ready), .key_loaded(key_loaded),
      .blk_count(blk_count)
   );

   aes_block_loader #(.CNT_W(16), .PERSIST_KEY(1'b0)) dut_np (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(1'b0),
      .s_valid(np_valid), .s_is_key(s_is_key), .s_data(s_data), .s_ready(np_s_ready),
      .ptext0(np_pt_b[0]), .ptext1(np_pt_b[1]), .ptext2(np_pt_b[2]), .ptext3(np_pt_b[3]),
      .ptext4(np_pt_b[4]), .ptext5(np_pt_b[5]), .ptext6(np_pt_b[6]), .ptext7(np_pt_b[7]),
      .ptext8(np_pt_b[8]), .ptext9(np_pt_b[9]), .ptext10(np_pt_b[10]), .ptext11(np_pt_b[11]),
      .ptext12(np_pt_b[12]), .ptext13(np_pt_b[13]), .ptext14(np_pt_b[14]), .ptext15(np_pt_b[15]),
      .key0(np_key_b[0]), .key1(np_key_b[1]), .key2(np_key_b[2]), .key3(np_key_b[3]),
      .key4(np_key_b[4]), .key5(np_key_b[5]), .key6(np_key_b[6]), .key7(np_key_b[7]),
      .key8(np_key_b[8]), .key9(np_key_b[9]), .key10(np_key_b[10]), .key11(np_key_b[11]),
      .key12(np_key_b[12]), .key13(np_key_b[13]), .key14(np_key_b[14]), .key15(np_key_b[15]),
      .out_valid(np_out_valid), .out_ready(np_ready), .key_loaded(np_key_loaded),
      .blk_count(np_blk_count)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Byte i of the vector is base + i*step.
   function automatic logic [127:0] ramp(input logic [7:0] base, input logic [7:0] step);
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = base + step * 8'(i);
      return v;
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Offer one byte and hold it until the selected DUT accepts it.
   task automatic send(input bit sel, input logic k, input logic [7:0] d);
      int   n;
      logic rdy;
      n = 0;
      rdy = 1'b0;
      s_is_key = k;
      s_data   = d;
      if (sel) np_valid = 1'b1; else s_valid = 1'b1;
      do begin
         @(negedge sys_clk);
         rdy = sel ? np_s_ready : s_ready;
         tick();
         n++;
      end while (!rdy && n < 500);
      if (!rdy) chk("send_timeout", 128'(rdy), 128'd1);
      s_valid  = 1'b0;
      np_valid = 1'b0;
   endtask

   task automatic send_block(input bit sel, input logic k, input logic [7:0] base,
                             input logic [7:0] step);
      for (int i = 0; i < 16; i++) send(sel, k, base + step * 8'(i));
   endtask

   task automatic push(input logic [127:0] pt, input logic [127:0] key, input logic [3:0] cnt);
      exp_t e;
      e.pt = pt; e.key = key; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic pulse_ready();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Check plaintext back-pressure in WAIT_KEY without letting a byte in.
   task automatic stall_check(input string name);
      s_is_key = 1'b0;
      s_valid  = 1'b1;
      @(negedge sys_clk);
      chk(name, 128'(s_ready), 128'd0);
      tick();
      s_valid = 1'b0;
   endtask

   // Scoreboard monitor: every handoff must match the oldest expected block.
   always @(negedge sys_clk) begin
      if (sys_rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_handoff", 128'(out_valid), 128'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_ptext", pt_bus, e.pt);
            chk("sb_key", key_bus, e.key);
            chk("sb_blk_count", 128'(blk_count), 128'(e.cnt));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] tmp, tmp2;
      sys_rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; np_valid = 1'b0;
      s_is_key = 1'b0; s_data = '0; out_ready = 1'b0; np_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_s_ready", 128'(s_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_key_loaded", 128'(key_loaded), 128'd0);
      chk("rst_blk_count", 128'(blk_count), 128'd0);
      chk("rst_ptext", pt_bus, 128'd0);
      tick();
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("post_rst_s_ready", 128'(s_ready), 128'd1);
      tick();

      // Non-persistent key: second block stalls until a fresh key arrives
      send_block(1'b1, 1'b1, 8'h30, 8'h01);
      send_block(1'b1, 1'b0, 8'h40, 8'h01);
      chk("np_out_valid", 128'(np_out_valid), 128'd1);
      chk("np_ptext", np_pt_bus, ramp(8'h40, 8'h01));
      chk("np_key", np_key_bus, ramp(8'h30, 8'h01));
      np_ready = 1'b1; tick(); np_ready = 1'b0;
      chk("np_key_cleared", 128'(np_key_loaded), 128'd0);
      chk("np_blk_count", 128'(np_blk_count), 128'd1);
      send_block(1'b1, 1'b0, 8'h50, 8'h01);
      chk("np_wait_key_ov", 128'(np_out_valid), 128'd0);
      s_is_key = 1'b0; np_valid = 1'b1;
      @(negedge sys_clk);
      chk("np_pt_stall", 128'(np_s_ready), 128'd0);
      tick(); np_valid = 1'b0;
      send_block(1'b1, 1'b1, 8'h60, 8'h01);
      chk("np_ov_after_key", 128'(np_out_valid), 128'd1);
      chk("np_key2", np_key_bus, ramp(8'h60, 8'h01));
      np_ready = 1'b1; tick(); np_ready = 1'b0;

      // FIPS-197 key then plaintext, 1-cycle latency, hold while not ready
      send_block(1'b0, 1'b1, 8'h00, 8'h01);
      chk("t1_key_loaded", 128'(key_loaded), 128'd1);
      push(ramp(8'h00, 8'h11), ramp(8'h00, 8'h01), 4'd0);
      for (int i = 0; i < 15; i++) send(1'b0, 1'b0, 8'(i * 17));
      chk("t1_ov_before_last", 128'(out_valid), 128'd0);
      send(1'b0, 1'b0, 8'hff);
      chk("t1_ov_latency", 128'(out_valid), 128'd1);
      repeat (5) tick();
      chk("t1_hold_ov", 128'(out_valid), 128'd1);
      chk("t1_hold_s_ready", 128'(s_ready), 128'd0);
      chk("t1_hold_ptext", pt_bus, ramp(8'h00, 8'h11));
      chk("t1_hold_key", key_bus, ramp(8'h00, 8'h01));
      pulse_ready();
      chk("t1_blk_count", 128'(blk_count), 128'd1);
      chk("t1_ov_drop", 128'(out_valid), 128'd0);
      chk("t1_back_to_fill", 128'(s_ready), 128'd1);

      // Plaintext before key: WAIT_KEY then release on key15
      flush = 1'b1; tick(); flush = 1'b0;
      send_block(1'b0, 1'b0, 8'h10, 8'h01);
      chk("t2_wait_ov", 128'(out_valid), 128'd0);
      stall_check("t2_pt_stall");
      push(ramp(8'h10, 8'h01), ramp(8'h20, 8'h01), 4'd1);
      send_block(1'b0, 1'b1, 8'h20, 8'h01);
      chk("t2_ov_after_key15", 128'(out_valid), 128'd1);
      pulse_ready();

      // Three back-to-back blocks under one persistent key
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         push(ramp(8'h50 + 8'(16 * b), 8'h01), ramp(8'h20, 8'h01), 4'(2 + b));
         send_block(1'b0, 1'b0, 8'h50 + 8'(16 * b), 8'h01);
      end
      tick(); tick();
      out_ready = 1'b0;
      chk("t3_blk_count", 128'(blk_count), 128'd5);
      chk("t3_key_kept", 128'(key_loaded), 128'd1);
      chk("t3_key_value", key_bus, ramp(8'h20, 8'h01));

      // Flush mid-block together with a valid byte
      for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 8'h40 + 8'(i));
      s_is_key = 1'b0; s_data = 8'hee; s_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      tmp  = ramp(8'h70, 8'h01);
      tmp2 = ramp(8'h40, 8'h01);
      tmp[63:0] = tmp2[63:0];
      chk("t4_flush_ptext", pt_bus, tmp);
      chk("t4_flush_key_loaded", 128'(key_loaded), 128'd0);
      chk("t4_flush_ov", 128'(out_valid), 128'd0);
      push(ramp(8'h80, 8'h01), ramp(8'h90, 8'h01), 4'd5);
      send_block(1'b0, 1'b0, 8'h80, 8'h01);
      chk("t4_wait_ov", 128'(out_valid), 128'd0);
      send_block(1'b0, 1'b1, 8'h90, 8'h01);
      chk("t4_ov", 128'(out_valid), 128'd1);
      pulse_ready();

      // Partial key reload
      for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 8'haa + 8'(i));
      tmp  = ramp(8'h90, 8'h01);
      tmp2 = ramp(8'haa, 8'h01);
      tmp[39:0] = tmp2[39:0];
      chk("t5_reload_key_loaded", 128'(key_loaded), 128'd0);
      chk("t5_reload_key", key_bus, tmp);
      send_block(1'b0, 1'b0, 8'hc0, 8'h01);
      chk("t5_wait_ov", 128'(out_valid), 128'd0);
      stall_check("t5_pt_stall");
      push(ramp(8'hc0, 8'h01), ramp(8'haa, 8'h01), 4'd6);
      for (int i = 5; i < 16; i++) send(1'b0, 1'b1, 8'haa + 8'(i));
      chk("t5_ov", 128'(out_valid), 128'd1);
      pulse_ready();
      chk("t5_blk_count", 128'(blk_count), 128'd7);

      // Counter wrap on the 4-bit build
      out_ready = 1'b1;
      for (int b = 0; b < 9; b++) begin
         push(ramp(8'(16 * b), 8'h01), ramp(8'haa, 8'h01), 4'(7 + b));
         send_block(1'b0, 1'b0, 8'(16 * b), 8'h01);
      end
      tick(); tick();
      out_ready = 1'b0;
      chk("t6_wrap", 128'(blk_count), 128'd0);
      push(ramp(8'he0, 8'h01), ramp(8'haa, 8'h01), 4'd0);
      send_block(1'b0, 1'b0, 8'he0, 8'h01);
      pulse_ready();
      chk("t6_after_wrap", 128'(blk_count), 128'd1);

      // Async reset while presenting
      send_block(1'b0, 1'b0, 8'hf0, 8'h01);
      chk("t6_present", 128'(out_valid), 128'd1);
      sys_rst_n = 1'b0;
      #1;
      chk("t6_rst_ov", 128'(out_valid), 128'd0);
      chk("t6_rst_blk_count", 128'(blk_count), 128'd0);
      chk("t6_rst_key_loaded", 128'(key_loaded), 128'd0);
      chk("t6_rst_s_ready", 128'(s_ready), 128'd0);
      chk("t6_rst_ptext", pt_bus, 128'd0);
      chk("t6_rst_key", key_bus, 128'd0);
      chk("sb_drained", 128'(sb.size()), 128'd0);
      repeat (2) tick();
      sys_rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
